// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in iclk cycles,
// tracks frequency lock against an expected half-period and flags loss of toggling.
module clk_period_meter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TOL         = 2,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             isig,
    input  logic [WIDTH-1:0] iexp_half,
    output logic [WIDTH-1:0] operiod,
    output logic [WIDTH-1:0] ohigh,
    output logic             ovalid,
    output logic             olock,
    output logic             otimeout
);

    localparam int unsigned     MW    = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]   LC_W  = MW'(LOCK_COUNT);
    localparam logic [WIDTH:0]  TOL_W = (WIDTH + 1)'(TOL);
    localparam logic [WIDTH-1:0] TO_W = WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   s, s_d, rise, fall, ready;
    logic [WIDTH-1:0]       cnt, hi_cap;
    logic [MW-1:0]          mcnt, mcnt_inc;
    logic [WIDTH:0]         exp2, cnt_w, hi_w, half_w, derr_p, derr_h;
    logic                   match;

    assign s     = sync_q[SYNC_STAGES-1];
    assign rise  = s & ~s_d;
    assign fall  = ~s & s_d;
    // Synchronizer resets to 0, so s is only trusted once it has been refilled
    // from isig; otherwise a high isig at reset release would look like a low.
    assign ready = prime_q[SYNC_STAGES-1];

    always_comb begin
        half_w   = {1'b0, iexp_half};
        exp2     = half_w << 1;
        cnt_w    = {1'b0, cnt};
        hi_w     = {1'b0, hi_cap};
        derr_p   = (cnt_w >= exp2)  ? cnt_w - exp2  : exp2 - cnt_w;
        derr_h   = (hi_w >= half_w) ? hi_w - half_w : half_w - hi_w;
        match    = (derr_p <= TOL_W) && (derr_h <= TOL_W) && (cnt != '1);
        mcnt_inc = (mcnt == LC_W) ? mcnt : mcnt + 1'b1;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state    <= IDLE;
            sync_q   <= '0;
            prime_q  <= '0;
            s_d      <= 1'b0;
            cnt      <= '0;
            hi_cap   <= '0;
            mcnt     <= '0;
            operiod  <= '0;
            ohigh    <= '0;
            ovalid   <= 1'b0;
            olock    <= 1'b0;
            otimeout <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], isig};
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            s_d     <= s;
            ovalid  <= 1'b0;

            if (rise)
                cnt <= WIDTH'(1);
            else if (cnt != '1)
                cnt <= cnt + 1'b1;

            if (fall)
                hi_cap <= cnt;

            case (state)
                IDLE: begin
                    if (ready && !s)
                        state <= ARM;
                end
                ARM: begin
                    if (rise) begin
                        state    <= MEAS;
                        otimeout <= 1'b0;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        operiod <= cnt;
                        ohigh   <= hi_cap;
                        ovalid  <= 1'b1;
                        if (match) begin
                            mcnt  <= mcnt_inc;
                            olock <= (mcnt_inc == LC_W);
                        end else begin
                            mcnt  <= '0;
                            olock <= 1'b0;
                        end
                    end else if (cnt == TO_W) begin
                        otimeout <= 1'b1;
                        olock    <= 1'b0;
                        mcnt     <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: reset, lock, duty tolerance, timeout,
// high-at-reset start-up and mid-period reset.
module tb_clk_period_meter;

    logic        iclk = 1'b0;
    logic        irst_n;
    logic        isig;
    logic [31:0] iexp_half;
    logic [31:0] operiod;
    logic [31:0] ohigh;
    logic        ovalid;
    logic        olock;
    logic        otimeout;

    int          n_assert = 0;
    int          n_fail   = 0;

    int          nv, vi, tfirst;
    logic [31:0] vp, vh;
    logic        vl, to_first, to_last, lk1002, lkto;

    clk_period_meter #(
        .WIDTH(32),
        .SYNC_STAGES(2),
        .TOL(2),
        .LOCK_COUNT(4),
        .TIMEOUT(1000)
    ) dut (
        .iclk(iclk),
        .irst_n(irst_n),
        .isig(isig),
        .iexp_half(iexp_half),
        .operiod(operiod),
        .ohigh(ohigh),
        .ovalid(ovalid),
        .olock(olock),
        .otimeout(otimeout)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    // One isig period (hi cycles high then lo low); logs any ovalid seen in it.
    task automatic per(input int hi, input int lo);
        nv = 0;
        vi = -1;
        vp = '0;
        vh = '0;
        vl = 1'b0;
        for (int i = 0; i < hi + lo; i++) begin
            isig = (i < hi);
            @(negedge iclk);
            if (i == 0) to_first = otimeout;
            to_last = otimeout;
            if (ovalid === 1'b1) begin
                if (nv == 0) vi = i;
                nv++;
                vp = operiod;
                vh = ohigh;
                vl = olock;
            end
            step();
        end
    endtask

    task automatic chk_per(input string tag, input int e_nv, input logic [31:0] e_p,
                           input logic [31:0] e_h, input logic e_l);
        chk({tag, ".nvalid"}, nv, e_nv);
        if (e_nv > 0) begin
            chk({tag, ".operiod"}, vp, e_p);
            chk({tag, ".ohigh"}, vh, e_h);
            chk({tag, ".olock"}, {31'b0, vl}, {31'b0, e_l});
        end
    endtask

    initial begin
        irst_n    = 1'b0;
        isig      = 1'b0;
        iexp_half = 32'd5;

        // Reset held while isig toggles
        for (int i = 0; i < 6; i++) begin
            isig = i[0];
            step();
        end
        @(negedge iclk);
        chk("rst.operiod", operiod, 0);
        chk("rst.ohigh", ohigh, 0);
        chk("rst.ovalid", {31'b0, ovalid}, 0);
        chk("rst.olock", {31'b0, olock}, 0);
        chk("rst.otimeout", {31'b0, otimeout}, 0);
        step();
        irst_n = 1'b1;
        isig   = 1'b0;

        per(0, 6);  chk_per("idle", 0, 0, 0, 1'b0);
        per(5, 5);  chk_per("p1", 0, 0, 0, 1'b0);
        per(5, 5);  chk_per("p2", 1, 10, 5, 1'b0);
        chk("p2.latency", vi, 3);
        per(5, 5);  chk_per("p3", 1, 10, 5, 1'b0);
        per(5, 5);  chk_per("p4", 1, 10, 5, 1'b0);
        per(5, 5);  chk_per("p5", 1, 10, 5, 1'b1);

        // Duty tolerance: 3/7 within TOL, 2/8 outside
        per(3, 7);  chk_per("p6", 1, 10, 5, 1'b1);
        per(2, 8);  chk_per("p7", 1, 10, 3, 1'b1);
        per(5, 5);  chk_per("p8", 1, 10, 2, 1'b0);

        per(5, 5);  chk_per("p9", 1, 10, 5, 1'b0);
        per(5, 5);  chk_per("p10", 1, 10, 5, 1'b0);
        per(5, 5);  chk_per("p11", 1, 10, 5, 1'b0);
        per(5, 5);  chk_per("p12", 1, 10, 5, 1'b1);

        // Last rise, then isig stuck low
        nv     = 0;
        vl     = 1'b0;
        tfirst = -1;
        lk1002 = 1'b0;
        lkto   = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            isig = (i < 5);
            @(negedge iclk);
            if (ovalid === 1'b1) begin
                nv++;
                vl = olock;
            end
            if (i == 1002) lk1002 = olock;
            if (otimeout === 1'b1 && tfirst < 0) begin
                tfirst = i;
                lkto   = olock;
            end
            step();
        end
        chk("to.nvalid", nv, 1);
        chk("to.lock_pre", {31'b0, vl}, 1);
        chk("to.lock_1002", {31'b0, lk1002}, 1);
        chk("to.when", tfirst, 1003);
        chk("to.lock_drop", {31'b0, lkto}, 0);

        per(5, 5);  chk_per("r1", 0, 0, 0, 1'b0);
        chk("r1.to_first", {31'b0, to_first}, 1);
        chk("r1.to_last", {31'b0, to_last}, 0);
        per(5, 5);  chk_per("r2", 1, 10, 5, 1'b0);

        // isig high through reset release
        irst_n = 1'b0;
        isig   = 1'b1;
        for (int i = 0; i < 4; i++) step();
        irst_n = 1'b1;
        per(8, 0);  chk_per("hi.hold", 0, 0, 0, 1'b0);
        per(0, 5);  chk_per("hi.low", 0, 0, 0, 1'b0);
        per(5, 5);  chk_per("hi.rise1", 0, 0, 0, 1'b0);
        per(5, 5);  chk_per("hi.rise2", 1, 10, 5, 1'b0);

        // Reset pulsed mid-period
        per(3, 0);
        chk("mr.pre_operiod", operiod, 10);
        irst_n = 1'b0;
        isig   = 1'b0;
        #1;
        chk("mr.operiod", operiod, 0);
        chk("mr.ohigh", ohigh, 0);
        chk("mr.ovalid", {31'b0, ovalid}, 0);
        chk("mr.olock", {31'b0, olock}, 0);
        chk("mr.otimeout", {31'b0, otimeout}, 0);
        for (int i = 0; i < 3; i++) step();
        irst_n = 1'b1;
        per(0, 6);  chk_per("mr.idle", 0, 0, 0, 1'b0);
        per(5, 5);  chk_per("mr.rise1", 0, 0, 0, 1'b0);
        per(5, 5);  chk_per("mr.rise2", 1, 10, 5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
